// File: rtl/lc3b_types.sv
// Shared LC-3b types: machine word, cache line, victim-buffer FSM state.
// Also holds the line-offset width used for line-granular address matching.
package lc3b_types;

    typedef logic [15:0]  lc3b_word;
    typedef logic [127:0] lc3b_line;

    // Byte-offset bits inside a 16-byte line; ignored when matching lines.
    localparam int OFFSET_W = 4;

    typedef enum logic [1:0] {
        IDLE,
        READ_MEM,
        DRAIN
    } vwb_state_t;

endpackage

// File: rtl/victim_line_reg.sv
// Storage for the single buffered victim line (valid/address/data).
// Ports: clk_i, rst_i (async, active-high), load_i (capture addr_i/data_i and
// set valid), clear_i (drop valid), tag_i (line tag to compare),
// valid_o/addr_o/data_o (held line), match_o (valid line with equal tag).
module victim_line_reg #(
    parameter int ADDR_W   = 16,
    parameter int LINE_W   = 128,
    parameter int OFFSET_W = lc3b_types::OFFSET_W
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       load_i,
    input  logic                       clear_i,
    input  logic [ADDR_W-1:0]          addr_i,
    input  logic [LINE_W-1:0]          data_i,
    input  logic [ADDR_W-OFFSET_W-1:0] tag_i,
    output logic                       valid_o,
    output logic [ADDR_W-1:0]          addr_o,
    output logic [LINE_W-1:0]          data_o,
    output logic                       match_o
);

    logic              valid_q;
    logic [ADDR_W-1:0] addr_q;
    logic [LINE_W-1:0] data_q;

    // A load always wins: a re-eviction of the same line overwrites in place.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_q <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
        end else if (load_i) begin
            valid_q <= 1'b1;
            addr_q  <= addr_i;
            data_q  <= data_i;
        end else if (clear_i) begin
            valid_q <= 1'b0;
        end
    end

    assign valid_o = valid_q;
    assign addr_o  = addr_q;
    assign data_o  = data_q;
    assign match_o = valid_q && (addr_q[ADDR_W-1:OFFSET_W] == tag_i);

endmodule

// File: rtl/victim_write_buffer.sv
// Single-entry victim write buffer between the cache and physical memory.
// Ports: clk, rst (async, active-high); cache side cache_read/cache_write/
// cache_address/cache_wdata in, cache_rdata/cache_resp out; memory side
// pmem_read/pmem_write/pmem_address/pmem_wdata out, pmem_rdata/pmem_resp in.
module victim_write_buffer #(
    parameter int ADDR_W   = 16,
    parameter int LINE_W   = $bits(lc3b_types::lc3b_line),
    parameter int OFFSET_W = lc3b_types::OFFSET_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cache_read,
    input  logic              cache_write,
    input  logic [ADDR_W-1:0] cache_address,
    input  logic [LINE_W-1:0] cache_wdata,
    output logic [LINE_W-1:0] cache_rdata,
    output logic              cache_resp,
    output logic              pmem_read,
    output logic              pmem_write,
    output logic [ADDR_W-1:0] pmem_address,
    output logic [LINE_W-1:0] pmem_wdata,
    input  logic [LINE_W-1:0] pmem_rdata,
    input  logic              pmem_resp
);

    import lc3b_types::*;

    vwb_state_t        state_q, state_d;
    logic              buf_load, buf_clear;
    logic              buf_valid, buf_match;
    logic [ADDR_W-1:0] buf_addr;
    logic [LINE_W-1:0] buf_data;

    victim_line_reg #(
        .ADDR_W   (ADDR_W),
        .LINE_W   (LINE_W),
        .OFFSET_W (OFFSET_W)
    ) u_line (
        .clk_i   (clk),
        .rst_i   (rst),
        .load_i  (buf_load),
        .clear_i (buf_clear),
        .addr_i  (cache_address),
        .data_i  (cache_wdata),
        .tag_i   (cache_address[ADDR_W-1:OFFSET_W]),
        .valid_o (buf_valid),
        .addr_o  (buf_addr),
        .data_o  (buf_data),
        .match_o (buf_match)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Responses are combinational; reset masks them so an eviction presented
    // while reset is held is neither acknowledged nor captured.
    always_comb begin
        state_d      = state_q;
        buf_load     = 1'b0;
        buf_clear    = 1'b0;
        pmem_read    = 1'b0;
        pmem_write   = 1'b0;
        pmem_address = buf_addr;
        pmem_wdata   = buf_data;
        cache_rdata  = buf_data;
        cache_resp   = 1'b0;
        if (!rst) begin
            unique case (state_q)
                IDLE: begin
                    if (cache_read) begin
                        if (buf_match) begin
                            cache_resp = 1'b1;
                        end else begin
                            state_d = READ_MEM;
                        end
                    end else if (cache_write) begin
                        if (!buf_valid || buf_match) begin
                            cache_resp = 1'b1;
                            buf_load   = 1'b1;
                        end else begin
                            state_d = DRAIN;
                        end
                    end else if (buf_valid) begin
                        state_d = DRAIN;
                    end
                end
                READ_MEM: begin
                    pmem_read    = 1'b1;
                    pmem_address = cache_address;
                    cache_rdata  = pmem_rdata;
                    cache_resp   = pmem_resp;
                    if (pmem_resp) begin
                        state_d = IDLE;
                    end
                end
                DRAIN: begin
                    pmem_write = 1'b1;
                    if (pmem_resp) begin
                        buf_clear = 1'b1;
                        state_d   = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_victim_write_buffer.sv
// Self-checking bench for victim_write_buffer: vector table plus sequences,
// with response and memory-write scoreboards.
module tb_victim_write_buffer;

    localparam int AW  = 16;
    localparam int LW  = 128;
    localparam int LAT = 3;

    localparam logic [LW-1:0] DA = {4{32'hAAAA_0001}};
    localparam logic [LW-1:0] DB = {4{32'hBBBB_0002}};
    localparam logic [LW-1:0] DC = {4{32'hCCCC_0003}};
    localparam logic [LW-1:0] DD = {4{32'hDDDD_0004}};
    localparam logic [LW-1:0] DE = {4{32'hEEEE_0005}};
    localparam logic [LW-1:0] DF = {4{32'hF0F0_0006}};
    localparam logic [LW-1:0] DG = {4{32'h1357_0007}};
    localparam logic [LW-1:0] DH = {4{32'h2468_0008}};

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cache_read = 1'b0;
    logic          cache_write = 1'b0;
    logic [AW-1:0] cache_address = '0;
    logic [LW-1:0] cache_wdata = '0;
    logic [LW-1:0] cache_rdata;
    logic          cache_resp;
    logic          pmem_read;
    logic          pmem_write;
    logic [AW-1:0] pmem_address;
    logic [LW-1:0] pmem_wdata;
    logic [LW-1:0] pmem_rdata = '0;
    logic          pmem_resp = 1'b0;

    int nchk = 0;
    int nfail = 0;
    int n_wr = 0;

    typedef struct {
        logic          rd;
        logic [LW-1:0] data;
    } rexp_t;

    typedef struct {
        logic [AW-1:0] addr;
        logic [LW-1:0] data;
    } wexp_t;

    typedef struct {
        logic          rd;
        logic          wr;
        logic [AW-1:0] addr;
        logic [LW-1:0] wdata;
        logic          exp_resp;
        logic [LW-1:0] exp_rdata;
    } vec_t;

    rexp_t rq[$];
    wexp_t wq[$];
    vec_t  tbl[5];

    bit mem_en = 1'b1;
    int mem_cnt = 0;

    victim_write_buffer dut (
        .clk           (clk),
        .rst           (rst),
        .cache_read    (cache_read),
        .cache_write   (cache_write),
        .cache_address (cache_address),
        .cache_wdata   (cache_wdata),
        .cache_rdata   (cache_rdata),
        .cache_resp    (cache_resp),
        .pmem_read     (pmem_read),
        .pmem_write    (pmem_write),
        .pmem_address  (pmem_address),
        .pmem_wdata    (pmem_wdata),
        .pmem_rdata    (pmem_rdata),
        .pmem_resp     (pmem_resp)
    );

    always #5 clk = ~clk;

    // Memory model: responds for one cycle after LAT cycles of a request.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            pmem_resp <= 1'b0;
            mem_cnt   <= 0;
        end else if (mem_en && (pmem_read || pmem_write) && !pmem_resp) begin
            if (mem_cnt == LAT - 1) begin
                pmem_resp <= 1'b1;
                mem_cnt   <= 0;
            end else begin
                mem_cnt <= mem_cnt + 1;
            end
        end else begin
            pmem_resp <= 1'b0;
            if (!(pmem_read || pmem_write)) mem_cnt <= 0;
        end
    end

    task automatic chk(input string nm, input logic [LW-1:0] act,
                       input logic [LW-1:0] exp);
        nchk++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp,
                     $time);
        end
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        nchk++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %b expected %b (t=%0t)", nm, act, exp,
                     $time);
        end
    endtask

    // Scoreboards: cache responses and completed memory writes.
    always @(negedge clk) begin
        if (!rst) begin
            if (cache_resp) begin
                if (rq.size() == 0) begin
                    nchk++;
                    nfail++;
                    $display("FAIL unexpected_resp: got resp with no request t=%0t",
                             $time);
                end else begin
                    rexp_t e;
                    e = rq.pop_front();
                    if (e.rd) chk("resp_rdata", cache_rdata, e.data);
                end
            end
            if (pmem_resp && pmem_write) begin
                n_wr++;
                if (wq.size() == 0) begin
                    nchk++;
                    nfail++;
                    $display("FAIL unexpected_write: addr %h t=%0t",
                             pmem_address, $time);
                end else begin
                    wexp_t w;
                    w = wq.pop_front();
                    chk("wr_addr", LW'(pmem_address), LW'(w.addr));
                    chk("wr_data", pmem_wdata, w.data);
                end
            end
            if (pmem_read && pmem_write) begin
                nchk++;
                nfail++;
                $display("FAIL rd_wr_overlap: got both asserted t=%0t", $time);
            end
        end
    end

    task automatic drive(input logic rd, input logic wr,
                         input logic [AW-1:0] a, input logic [LW-1:0] d);
        @(posedge clk);
        #1;
        cache_read    = rd;
        cache_write   = wr;
        cache_address = a;
        cache_wdata   = d;
    endtask

    task automatic push_r(input logic rd, input logic [LW-1:0] d);
        rexp_t e;
        e.rd   = rd;
        e.data = d;
        rq.push_back(e);
    endtask

    task automatic push_w(input logic [AW-1:0] a, input logic [LW-1:0] d);
        wexp_t w;
        w.addr = a;
        w.data = d;
        wq.push_back(w);
    endtask

    task automatic wait_resp(input int budget, output int cyc);
        cyc = 0;
        while (!cache_resp && cyc < budget) begin
            @(negedge clk);
            cyc++;
        end
        if (!cache_resp) begin
            nchk++;
            nfail++;
            $display("FAIL resp_timeout: got no resp expected resp within %0d",
                     budget);
        end
    endtask

    task automatic wait_writes(input int target, input int budget);
        int k;
        k = 0;
        while (n_wr < target && k < budget) begin
            @(negedge clk);
            #1;
            k++;
        end
        chk("drain_done", LW'(n_wr), LW'(target));
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got hang expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int c;
        int pr;
        int cr;
        int wcnt;

        tbl[0] = '{1'b0, 1'b1, 16'h1230, DA, 1'b1, '0};
        tbl[1] = '{1'b1, 1'b0, 16'h1238, '0, 1'b1, DA};
        tbl[2] = '{1'b0, 1'b1, 16'h1234, DC, 1'b1, '0};
        tbl[3] = '{1'b1, 1'b0, 16'h1230, '0, 1'b1, DC};
        tbl[4] = '{1'b1, 1'b0, 16'h123C, '0, 1'b1, DC};

        // Reset state, with an eviction presented while reset is held.
        cache_write   = 1'b1;
        cache_address = 16'h1230;
        cache_wdata   = DA;
        #2;
        chk1("rst_resp", cache_resp, 1'b0);
        chk1("rst_pmem_read", pmem_read, 1'b0);
        chk1("rst_pmem_write", pmem_write, 1'b0);
        chk("rst_pmem_addr", LW'(pmem_address), '0);
        chk("rst_pmem_wdata", pmem_wdata, '0);
        chk("rst_rdata", cache_rdata, '0);
        cache_write = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Table: evictions and hits back to back, buffer never drains.
        push_w(16'h1234, DC);
        for (int i = 0; i < 5; i++) begin
            drive(tbl[i].rd, tbl[i].wr, tbl[i].addr, tbl[i].wdata);
            if (tbl[i].exp_resp) push_r(tbl[i].rd, tbl[i].exp_rdata);
            @(negedge clk);
            chk1($sformatf("vec%0d_resp", i), cache_resp, tbl[i].exp_resp);
            chk1($sformatf("vec%0d_pmem_read", i), pmem_read, 1'b0);
            chk1($sformatf("vec%0d_pmem_write", i), pmem_write, 1'b0);
        end
        drive(1'b0, 1'b0, '0, '0);
        wait_writes(1, 20);
        repeat (5) @(negedge clk);
        chk("single_drain", LW'(n_wr), LW'(1));

        // Evict into empty buffer, then a miss read served by memory.
        pmem_rdata = DB;
        drive(1'b0, 1'b1, 16'h1230, DA);
        push_r(1'b0, '0);
        push_w(16'h1230, DA);
        @(negedge clk);
        chk1("evict_resp", cache_resp, 1'b1);
        drive(1'b1, 1'b0, 16'h5670, '0);
        push_r(1'b1, DB);
        @(negedge clk);
        chk1("miss_no_resp", cache_resp, 1'b0);
        chk1("miss_no_pread_yet", pmem_read, 1'b0);
        @(negedge clk);
        chk1("miss_pmem_read", pmem_read, 1'b1);
        chk("miss_pmem_addr", LW'(pmem_address), LW'(16'h5670));
        chk1("miss_no_pwrite", pmem_write, 1'b0);
        wait_resp(10, c);
        chk("miss_latency", LW'(c), LW'(LAT));
        drive(1'b0, 1'b0, '0, '0);
        wait_writes(2, 20);

        // Eviction into a full non-matching buffer waits for the drain.
        push_w(16'h1230, DA);
        push_w(16'h4440, DD);
        drive(1'b0, 1'b1, 16'h1230, DA);
        push_r(1'b0, '0);
        @(negedge clk);
        chk1("full_first_resp", cache_resp, 1'b1);
        drive(1'b0, 1'b1, 16'h4440, DD);
        push_r(1'b0, '0);
        @(negedge clk);
        chk1("full_stall", cache_resp, 1'b0);
        pr = -1;
        cr = -1;
        for (int i = 1; i < 20 && cr < 0; i++) begin
            @(negedge clk);
            if (i == 1) begin
                chk1("full_drain_write", pmem_write, 1'b1);
                chk("full_drain_addr", LW'(pmem_address), LW'(16'h1230));
            end
            if (pmem_resp && pmem_write && pr < 0) pr = i;
            if (cache_resp) cr = i;
        end
        chk("full_resp_after_drain", LW'(cr - pr), LW'(1));
        drive(1'b0, 1'b0, '0, '0);
        wait_writes(4, 20);

        // Idle buffer drains opportunistically one cycle later.
        pmem_rdata = DE;
        push_w(16'h1230, DA);
        drive(1'b0, 1'b1, 16'h1230, DA);
        push_r(1'b0, '0);
        @(negedge clk);
        chk1("idle_evict_resp", cache_resp, 1'b1);
        drive(1'b0, 1'b0, '0, '0);
        @(negedge clk);
        chk1("idle_not_yet", pmem_write, 1'b0);
        @(negedge clk);
        chk1("idle_drain_start", pmem_write, 1'b1);
        wait_writes(5, 20);
        @(negedge clk);
        chk1("idle_drain_end", pmem_write, 1'b0);
        drive(1'b1, 1'b0, 16'h1230, '0);
        push_r(1'b1, DE);
        @(negedge clk);
        chk1("post_drain_miss", cache_resp, 1'b0);
        wait_resp(10, c);
        drive(1'b0, 1'b0, '0, '0);

        // Read and write together: the read wins; empty buffer never drains.
        pmem_rdata = DF;
        drive(1'b1, 1'b1, 16'h7770, DG);
        push_r(1'b1, DF);
        @(negedge clk);
        chk1("rd_wins", cache_resp, 1'b0);
        wait_resp(10, c);
        drive(1'b0, 1'b0, '0, '0);
        wcnt = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (pmem_write) wcnt++;
        end
        chk("no_drain_empty", LW'(wcnt), '0);

        // Reset in the middle of a drain abandons the line.
        mem_en = 1'b0;
        drive(1'b0, 1'b1, 16'h1230, DA);
        push_r(1'b0, '0);
        @(negedge clk);
        chk1("mid_evict_resp", cache_resp, 1'b1);
        drive(1'b0, 1'b0, '0, '0);
        @(negedge clk);
        @(negedge clk);
        chk1("mid_draining", pmem_write, 1'b1);
        chk("mid_drain_addr", LW'(pmem_address), LW'(16'h1230));
        #2;
        rst = 1'b1;
        #1;
        chk1("mid_rst_write_drop", pmem_write, 1'b0);
        chk("mid_rst_addr", LW'(pmem_address), '0);
        chk("mid_rst_wdata", pmem_wdata, '0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        mem_en = 1'b1;
        pmem_rdata = DH;
        drive(1'b1, 1'b0, 16'h1230, '0);
        push_r(1'b1, DH);
        @(negedge clk);
        chk1("post_rst_read_miss", cache_resp, 1'b0);
        wait_resp(10, c);
        drive(1'b0, 1'b0, '0, '0);
        repeat (3) @(negedge clk);

        chk("resp_queue_empty", LW'(rq.size()), '0);
        chk("write_queue_empty", LW'(wq.size()), '0);
        chk("total_writes", LW'(n_wr), LW'(5));

        $display("End of test - %0d assertions evaluated, %0d failures",
                 nchk, nfail);
        $finish;
    end

endmodule
